// File: rtl/pipe_fetch_ctrl.sv
// PC / IF/ID owner for the 5-stage pipeline: fetch, stall hold, redirect flush, HALT drain.
// All state moves on the clk edge; imem_addr and idex_bubble are combinational; stall holds PC and IF/ID.
module pipe_fetch_ctrl #(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter logic [15:0] NOP_INSTR    = 16'h0800,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt_dec,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] ifid_instr,
  output logic [15:0] ifid_pc2,
  output logic        ifid_valid,
  output logic        idex_bubble,
  output logic        halted,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_t;

  state_t        state, state_nxt;
  logic [15:0]   pc, pc_nxt, pc_plus2;
  logic [15:0]   instr_nxt, pc2_nxt;
  logic          valid_nxt;
  logic [CW-1:0] drain_cnt, drain_cnt_nxt;
  logic [15:0]   stall_cnt_nxt, flush_cnt_nxt;

  assign imem_addr   = pc;
  assign halted      = (state == ST_HALT);
  assign idex_bubble = stall | redirect | ~ifid_valid | (state != ST_RUN);
  assign pc_plus2    = pc + 16'd2;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    instr_nxt     = ifid_instr;
    pc2_nxt       = ifid_pc2;
    valid_nxt     = ifid_valid;
    drain_cnt_nxt = drain_cnt;
    stall_cnt_nxt = stall_cnt;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_RUN: begin
        if (redirect) begin
          pc_nxt        = redirect_pc;
          instr_nxt     = NOP_INSTR;
          valid_nxt     = 1'b0;
          flush_cnt_nxt = (flush_cnt == 16'hFFFF) ? flush_cnt : flush_cnt + 16'd1;
        end else if (halt_dec && ifid_valid) begin
          // The HALT itself is squashed here; EX/MEM/WB finish while we drain.
          state_nxt     = ST_DRAIN;
          drain_cnt_nxt = '0;
          instr_nxt     = NOP_INSTR;
          valid_nxt     = 1'b0;
        end else if (stall) begin
          stall_cnt_nxt = (stall_cnt == 16'hFFFF) ? stall_cnt : stall_cnt + 16'd1;
        end else begin
          pc_nxt    = pc_plus2;
          instr_nxt = imem_data;
          pc2_nxt   = pc_plus2;
          valid_nxt = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_HALT;
        end else begin
          drain_cnt_nxt = drain_cnt + 1'b1;
        end
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
      default: begin
        state_nxt = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      ifid_instr <= NOP_INSTR;
      ifid_pc2   <= 16'h0000;
      ifid_valid <= 1'b0;
      drain_cnt  <= '0;
      stall_cnt  <= 16'h0000;
      flush_cnt  <= 16'h0000;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      ifid_instr <= instr_nxt;
      ifid_pc2   <= pc2_nxt;
      ifid_valid <= valid_nxt;
      drain_cnt  <= drain_cnt_nxt;
      stall_cnt  <= stall_cnt_nxt;
      flush_cnt  <= flush_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Scoreboarded bench for pipe_fetch_ctrl: directed scenarios, random traffic, stall counter saturation.
module tb_pipe_fetch_ctrl;

  localparam logic [15:0] RESET_PC  = 16'h0000;
  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam int          DRAIN     = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt_dec = 1'b0;
  logic [15:0] imem_data;
  logic [15:0] imem_addr, ifid_instr, ifid_pc2, stall_cnt, flush_cnt;
  logic        ifid_valid, idex_bubble, halted;

  pipe_fetch_ctrl #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt_dec(halt_dec), .imem_data(imem_data), .imem_addr(imem_addr), .ifid_instr(ifid_instr),
    .ifid_pc2(ifid_pc2), .ifid_valid(ifid_valid), .idex_bubble(idex_bubble), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] imem_fn(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  assign imem_data = imem_fn(imem_addr);

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc2;
    logic        valid;
    logic        bubble;
    logic        halted;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: architectural view of the fetch stage.
  logic [15:0] m_pc, m_instr, m_pc2, m_scnt, m_fcnt;
  logic        m_valid, m_draining;
  int          m_drain_edges;

  task automatic model_step(input logic r, input logic s, input logic rd,
                            input logic [15:0] rp, input logic h);
    logic [15:0] nxt;
    if (!r) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc2 = 16'h0000; m_valid = 1'b0;
      m_draining = 1'b0; m_drain_edges = 0; m_scnt = 16'h0000; m_fcnt = 16'h0000;
    end else if (!m_draining) begin
      if (rd) begin
        m_pc = rp; m_instr = NOP_INSTR; m_valid = 1'b0;
        if (m_fcnt != 16'hFFFF) m_fcnt = m_fcnt + 16'd1;
      end else if (h && m_valid) begin
        m_draining = 1'b1; m_drain_edges = 0; m_instr = NOP_INSTR; m_valid = 1'b0;
      end else if (s) begin
        if (m_scnt != 16'hFFFF) m_scnt = m_scnt + 16'd1;
      end else begin
        nxt = m_pc + 16'd2;
        m_instr = imem_fn(m_pc); m_pc2 = nxt; m_pc = nxt; m_valid = 1'b1;
      end
    end else if (m_drain_edges < DRAIN) begin
      m_drain_edges++;
    end
  endtask

  // One cycle: account for the edge just taken, then drive new inputs and predict outputs.
  task automatic cyc(input logic r, input logic s, input logic rd,
                     input logic [15:0] rp, input logic h);
    exp_t e;
    @(posedge clk);
    #1;
    model_step(rst_n, stall, redirect, redirect_pc, halt_dec);
    rst_n = r; stall = s; redirect = rd; redirect_pc = rp; halt_dec = h;
    e.addr   = m_pc;
    e.instr  = m_instr;
    e.pc2    = m_pc2;
    e.valid  = m_valid;
    e.bubble = s | rd | ~m_valid | m_draining;
    e.halted = m_draining && (m_drain_edges >= DRAIN);
    e.scnt   = m_scnt;
    e.fcnt   = m_fcnt;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, req);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("imem_addr",   imem_addr,          e.addr);
        chk("ifid_instr",  ifid_instr,         e.instr);
        chk("ifid_valid",  {15'd0, ifid_valid}, {15'd0, e.valid});
        if (e.valid) chk("ifid_pc2", ifid_pc2, e.pc2);
        chk("idex_bubble", {15'd0, idex_bubble}, {15'd0, e.bubble});
        chk("halted",      {15'd0, halted},      {15'd0, e.halted});
        chk("stall_cnt",   stall_cnt,          e.scnt);
        chk("flush_cnt",   flush_cnt,          e.fcnt);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset, then free-running fetch.
    repeat (2) cyc(0, 0, 0, 16'h0000, 0);
    repeat (3) cyc(1, 0, 0, 16'h0000, 0);
    // Stall three cycles at PC=6, then resume.
    repeat (3) cyc(1, 1, 0, 16'h0000, 0);
    repeat (3) cyc(1, 0, 0, 16'h0000, 0);
    // Redirect together with stall: redirect wins.
    cyc(1, 1, 1, 16'h0040, 0);
    repeat (3) cyc(1, 0, 0, 16'h0000, 0);
    // PC wrap from FFFE.
    cyc(1, 0, 1, 16'hFFFE, 0);
    repeat (3) cyc(1, 0, 0, 16'h0000, 0);
    // HALT drain with stray stall/redirect pulses, then reset out of HALT.
    cyc(1, 0, 0, 16'h0000, 1);
    cyc(1, 1, 0, 16'h0000, 0);
    cyc(1, 0, 1, 16'h1234, 0);
    cyc(1, 1, 1, 16'h2222, 1);
    cyc(1, 0, 1, 16'h3333, 0);
    cyc(1, 1, 0, 16'h0000, 1);
    cyc(0, 0, 0, 16'h0000, 0);
    repeat (3) cyc(1, 0, 0, 16'h0000, 0);
    // Reset in the middle of DRAIN.
    cyc(1, 0, 0, 16'h0000, 1);
    cyc(1, 0, 0, 16'h0000, 0);
    cyc(0, 0, 0, 16'h0000, 0);
    repeat (3) cyc(1, 0, 0, 16'h0000, 0);
    // halt_dec while IF/ID is empty is ignored.
    cyc(1, 0, 1, 16'h0100, 0);
    cyc(1, 0, 0, 16'h0000, 1);
    repeat (2) cyc(1, 0, 0, 16'h0000, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, rd, h;
      logic [15:0] rp;
      r  = ($urandom_range(0, 99) >= 2);
      s  = ($urandom_range(0, 99) < 25);
      rd = ($urandom_range(0, 99) < 10);
      h  = ($urandom_range(0, 99) < 4);
      rp = 16'($urandom);
      cyc(r, s, rd, rp, h);
    end

    // Stall counter saturation.
    cyc(0, 0, 0, 16'h0000, 0);
    cyc(1, 0, 0, 16'h0000, 0);
    for (int i = 0; i < 65540; i++) cyc(1, 1, 0, 16'h0000, 0);
    repeat (2) cyc(1, 0, 0, 16'h0000, 0);

    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
